// File: rtl/shift_add_multiplier_8bit_if.sv
// Handshake and data bundle for the sequential 8x8 shift-add multiplier.
// The requester drives start and operands; the multiplier returns status and the product.
interface shift_add_multiplier_8bit_if;
  logic        start;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, in1, in2,
    input  busy, done, product
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-add multiplier: one ripple-carry adder reused over
// eight clocked iterations, with the adder carry kept as the ninth bit of each step.
module ripple_carry_adder_8bit (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  output logic [7:0] out,
  output logic       carry_out
);
  logic [8:0] carry;

  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_bit
      assign out[i]       = in1[i] ^ in2[i] ^ carry[i];
      assign carry[i + 1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end
  endgenerate

  assign carry_out = carry[8];
endmodule

module shift_add_multiplier_8bit (
  input  logic                        clk,
  input  logic                        rst,
  shift_add_multiplier_8bit_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  m_reg;
  logic [7:0]  a_reg;
  logic [7:0]  q_reg;
  logic [2:0]  cnt;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] product_reg;

  logic [7:0]  sum;
  logic        c;
  logic [8:0]  step;

  ripple_carry_adder_8bit u_adder (
    .in1       (a_reg),
    .in2       (m_reg),
    .out       (sum),
    .carry_out (c)
  );

  // Nine-bit partial result; its LSB falls into Q and the carry lands in A[7].
  always_comb begin
    step = {1'b0, a_reg};
    if (q_reg[0]) begin
      step = {c, sum};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m_reg       <= 8'h00;
      a_reg       <= 8'h00;
      q_reg       <= 8'h00;
      cnt         <= 3'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (bus.start) begin
            m_reg    <= bus.in1;
            q_reg    <= bus.in2;
            a_reg    <= 8'h00;
            cnt      <= 3'd0;
            busy_reg <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          a_reg <= step[8:1];
          q_reg <= {step[0], q_reg[7:1]};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            done_reg <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          product_reg <= {a_reg, q_reg};
          done_reg    <= 1'b0;
          busy_reg    <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Self-checking bench for shift_add_multiplier_8bit: directed corner cases plus
// randomized operands compared against plain integer multiplication.
module tb_shift_add_multiplier_8bit;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  shift_add_multiplier_8bit_if bus ();

  shift_add_multiplier_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Presents operands with start high across exactly one rising edge (the accept edge).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in1   = 8'h00;
    bus.in2   = 8'h00;
    #2;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b required 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done: got %b required 0", bus.done);
    end
    vectors++;
    if (bus.product !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_product: got %h required 0000", bus.product);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int done_count;
    done_count = 0;
    start_op(8'h00, 8'h00);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL zero_busy_rise: got %b required 1", bus.busy);
    end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_count++;
      vectors++;
      if (bus.busy !== (i <= 8)) begin
        miscompares++;
        $display("[TB] FAIL zero_busy edge %0d: got %b required %b", i, bus.busy, (i <= 8));
      end
      vectors++;
      if (bus.done !== (i == 8)) begin
        miscompares++;
        $display("[TB] FAIL zero_done edge %0d: got %b required %b", i, bus.done, (i == 8));
      end
    end
    vectors++;
    if (done_count != 1) begin
      miscompares++;
      $display("[TB] FAIL zero_done_count: got %0d required 1", done_count);
    end
    vectors++;
    if (bus.product !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL zero_product: got %h required 0000", bus.product);
    end
  endtask

  task automatic test_max();
    start_op(8'hFF, 8'hFF);
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (bus.product !== 16'hFE01 || bus.product !== ref_mul(8'hFF, 8'hFF)) begin
      miscompares++;
      $display("[TB] FAIL max_product: got %h required fe01", bus.product);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a_ops [3];
    logic [7:0]  b_ops [3];
    logic [15:0] prev;
    a_ops = '{8'h0D, 8'h80, 8'h01};
    b_ops = '{8'h0B, 8'h02, 8'hFF};
    prev  = 16'hFE01;
    bus.in1   = a_ops[0];
    bus.in2   = b_ops[0];
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.in1   = 8'h5A;
      bus.in2   = 8'hA5;
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_accept op %0d: busy got %b required 1", k, bus.busy);
      end
      for (int i = 1; i <= 9; i++) begin
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== (i == 8)) begin
          miscompares++;
          $display("[TB] FAIL b2b_done op %0d edge %0d: got %b required %b", k, i, bus.done, (i == 8));
        end
        if (i < 9) begin
          vectors++;
          if (bus.product !== prev) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold op %0d edge %0d: got %h required %h", k, i, bus.product, prev);
          end
        end else begin
          prev = ref_mul(a_ops[k], b_ops[k]);
          vectors++;
          if (bus.product !== prev) begin
            miscompares++;
            $display("[TB] FAIL b2b_product op %0d: got %h required %h", k, bus.product, prev);
          end
          if (k < 2) begin
            bus.in1   = a_ops[k + 1];
            bus.in2   = b_ops[k + 1];
            bus.start = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_start_held();
    logic [7:0] a0, b0, a1, b1;
    a0 = 8'($urandom_range(255, 0));
    b0 = 8'($urandom_range(255, 0));
    a1 = 8'h00;
    b1 = 8'h00;
    bus.in1   = a0;
    bus.in2   = b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 10; i++) begin
      bus.in1 = 8'($urandom_range(255, 0));
      bus.in2 = 8'($urandom_range(255, 0));
      if (i == 10) begin
        a1 = bus.in1;
        b1 = bus.in2;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.done !== (i == 8)) begin
        miscompares++;
        $display("[TB] FAIL held_done edge %0d: got %b required %b", i, bus.done, (i == 8));
      end
      if (i == 9) begin
        vectors++;
        if (bus.product !== ref_mul(a0, b0)) begin
          miscompares++;
          $display("[TB] FAIL held_product1: got %h required %h", bus.product, ref_mul(a0, b0));
        end
      end
      if (i == 10) begin
        vectors++;
        if (bus.busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL held_reaccept: busy got %b required 1", bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      bus.in1 = 8'($urandom_range(255, 0));
      bus.in2 = 8'($urandom_range(255, 0));
      @(posedge clk);
      #1;
      vectors++;
      if (bus.done !== (j == 8)) begin
        miscompares++;
        $display("[TB] FAIL held_done2 edge %0d: got %b required %b", j, bus.done, (j == 8));
      end
    end
    vectors++;
    if (bus.product !== ref_mul(a1, b1)) begin
      miscompares++;
      $display("[TB] FAIL held_product2: got %h required %h", bus.product, ref_mul(a1, b1));
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    start_op(8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got busy=%b done=%b product=%h required 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_activity: got %0d active cycles required 0", seen_done);
    end
    start_op(8'h12, 8'h34);
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (bus.product !== 16'h03A8 || bus.product !== ref_mul(8'h12, 8'h34)) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart_product: got %h required 03a8", bus.product);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    int         lat;
    for (int n = 0; n < 200; n++) begin
      case (n)
        0:       begin a = 8'h00; b = 8'hFF; end
        1:       begin a = 8'hFF; b = 8'h01; end
        2:       begin a = 8'h80; b = 8'h80; end
        3:       begin a = 8'hFF; b = 8'hFE; end
        default: begin
          a = 8'($urandom_range(255, 0));
          b = 8'($urandom_range(255, 0));
        end
      endcase
      start_op(a, b);
      bus.in1 = ~a;
      bus.in2 = ~b;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) lat = c;
      end
      vectors++;
      if (lat != 8) begin
        miscompares++;
        $display("[TB] FAIL rand_latency %h*%h: got %0d edges required 8", a, b, lat);
      end
      if (lat != 0) begin
        @(posedge clk);
        #1;
        vectors++;
        if (bus.product !== ref_mul(a, b)) begin
          miscompares++;
          $display("[TB] FAIL rand_product %h*%h: got %h required %h", a, b, bus.product, ref_mul(a, b));
        end
      end else begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
